tinyqv_irq_ctrl: RTL and testbench
==================================

Name: tinyqv_irq_ctrl

Overview:
Parametrised interrupt controller for the nibble-serial TinyQV core. It generalises the fixed 4-line mip/mie logic to NUM_IRQ lines, each with a per-line edge/level mode and a configurable synchroniser depth. It exposes mie/mip as nibble-serial CSRs and raises interrupt_pending toward the core. On interrupt entry it latches a fixed-priority line ID.

Parameters:
NUM_IRQ, 4, number of interrupt lines (1..16)
IRQ_BASE, 16, bit position of line 0 in mip/mie; multiple of 4; IRQ_BASE+NUM_IRQ <= 32
EDGE_MASK, 16'h0003, bit i=1 makes line i rising-edge triggered with a sticky pending bit; 0 makes it level (mip follows input)
SYNC_STAGES, 0, synchroniser flops on irq_in (0..3)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
counter  in  3  sub-cycle nibble index; increments every clock
irq_in  in  NUM_IRQ  raw interrupt requests
csr_addr  in  12  CSR address of the current instruction (imm_lo)
csr_op  in  2  00 none, 01 write, 10 set, 11 clear
csr_wdata  in  4  rs1 nibble for the current counter
take_irq  in  1  core is executing an interrupt entry (sampled at counter==0)
global_ie  in  1  mstatus.MIE
clear_all  in  1  double-fault recovery; synchronous clear
csr_rdata  out  4  read nibble; 0 if csr_addr is not 0x304/0x344
interrupt_pending  out  1  global_ie && |(mip & mie)
irq_id  out  4  line index latched at the last take

Behaviour:
- Reset (rstn low, async): mie=0, edge pending=0, sync/history flops=0, irq_id=0; outputs csr_rdata=0, interrupt_pending=0.
- Bit mapping: CSR bit IRQ_BASE+i is line i. At counter k, nibble bits [4k+3:4k] are active. Bits outside the line range read 0 and ignore writes.
- mie (0x304): write/set/clear applied per nibble at its counter. Read returns mie nibble.
- mip (0x344): level line bit = synchronised input, read-only. Edge line bit = sticky pending flop; writable via write/set/clear.
- Synchroniser: irq_s = irq_in delayed SYNC_STAGES clocks. Edge detect = irq_s & ~irq_s_prev, evaluated every clock.
- Pending latency: a rising edge at irq_in becomes visible in mip and interrupt_pending exactly SYNC_STAGES+1 clocks later. Level lines have latency SYNC_STAGES.
- Simultaneous detected edge and CSR clear/write-0 on the same bit and cycle: the edge wins, so no interrupt is lost.
- interrupt_pending is combinational from registered state and global_ie. It has no dependence on csr inputs.
- take_irq && counter==0: irq_id <= lowest i with mip[i]&mie[i]. If none, irq_id holds. The core owns mcause and forms it as {1, IRQ_BASE+irq_id}.
- clear_all (any counter): mie=0 and all edge pending=0 next clock. Sync and history flops are kept.
- Async reset mid-instruction: all state clears immediately. The first edge after release needs SYNC_STAGES+1 clocks.
- csr_op==00 or a non-matching address: no state change.

Optional Feature:
TINYQV_IRQ_VECTORED_EN
- Defined: adds output vec_offset [6:0] = 4*(IRQ_BASE+irq_id), registered together with irq_id. The core adds it to mtvec for vectored dispatch.
- Undefined: port is absent, no extra logic, all other behaviour is identical.

Decomposition:
- Package tinyqv_irq_pkg holds:
  - CSR address constants CSR_MIE=12'h304 and CSR_MIP=12'h344;
  - csr_op encodings;
  - a localparam helper for the nibble range.
- Natural sub-module tinyqv_irq_line: one line's synchroniser, edge detect and pending flop with CSR update. Instantiate it NUM_IRQ times through a generate loop.

Test Plan:
- Reset, defaults, SYNC_STAGES=0: pulse irq_in[0] 0->1; mie=0x10000 via csrw at counter 4 → mip bit16 set 1 clock after the edge. interrupt_pending=1 when global_ie=1, 0 when global_ie=0.
- Level line 2 (EDGE_MASK bit 2=0): hold irq_in[2]=1 → mip reads 0x4 at counter 4. Drop irq_in[2] → reads 0 next clock. A csrs to mip bit18 has no effect.
- Priority: lines 1 and 3 pending and enabled; take_irq at counter 0 → irq_id=1 (vec_offset=68 if vectored). Clear line 1 pending then take → irq_id=3.
- Race: edge on line 0 in the same clock as csrc mip 0x10000 → pending stays 1.
- SYNC_STAGES=2, NUM_IRQ=16, IRQ_BASE=16: edge on line 15 → mip bit31 (counter 7 nibble 0x8) visible exactly 3 clocks later.
- clear_all with mie=0xF and pending=0x3 → both 0 next clock and interrupt_pending=0. Assert rstn low mid-csrw → mie=0 immediately.

Source files
------------

// File: rtl/tinyqv_irq_pkg.sv
// Shared CSR addresses, CSR op encodings and nibble helpers for the TinyQV interrupt controller.
package tinyqv_irq_pkg;

  localparam logic [11:0] CSR_MIE = 12'h304;
  localparam logic [11:0] CSR_MIP = 12'h344;
  localparam int          NIB_W   = 4;

  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  // Sub-cycle counter value at which a CSR bit position is on the nibble bus.
  function automatic logic [2:0] nib_of(input int bit_pos);
    return 3'(bit_pos / NIB_W);
  endfunction

  function automatic logic csr_apply(input csr_op_e op, input logic cur, input logic wbit);
    case (op)
      CSR_OP_WRITE: return wbit;
      CSR_OP_SET:   return cur | wbit;
      CSR_OP_CLEAR: return cur & ~wbit;
      default:      return cur;
    endcase
  endfunction

endpackage

// File: rtl/tinyqv_irq_ctrl_if.sv
// Core-side bundle of the interrupt controller: nibble-serial CSR access, irq lines, status.
// vec_offset exists only when TINYQV_IRQ_VECTORED_EN is defined.
interface tinyqv_irq_ctrl_if #(
  parameter int NUM_IRQ = 4
);
  logic [2:0]         counter;
  logic [NUM_IRQ-1:0] irq_in;
  logic [11:0]        csr_addr;
  logic [1:0]         csr_op;
  logic [3:0]         csr_wdata;
  logic               take_irq;
  logic               global_ie;
  logic               clear_all;
  logic [3:0]         csr_rdata;
  logic               interrupt_pending;
  logic [3:0]         irq_id;
`ifdef TINYQV_IRQ_VECTORED_EN
  logic [6:0]         vec_offset;
`endif

  modport master (
    output counter, irq_in, csr_addr, csr_op, csr_wdata, take_irq, global_ie, clear_all,
    input  csr_rdata, interrupt_pending, irq_id
`ifdef TINYQV_IRQ_VECTORED_EN
    , input vec_offset
`endif
  );

  modport slave (
    input  counter, irq_in, csr_addr, csr_op, csr_wdata, take_irq, global_ie, clear_all,
    output csr_rdata, interrupt_pending, irq_id
`ifdef TINYQV_IRQ_VECTORED_EN
    , output vec_offset
`endif
  );

endinterface

// File: rtl/tinyqv_irq_line.sv
// One interrupt line: SYNC_STAGES-deep synchroniser, rising-edge detect and sticky pending flop.
// Edge mode: pending one clock after the synchronised edge; level mode: mip is the synchronised input.
module tinyqv_irq_line
  import tinyqv_irq_pkg::*;
#(
  parameter logic EDGE        = 1'b1,
  parameter int   SYNC_STAGES = 0
) (
  input  logic    clk,
  input  logic    rstn,
  input  logic    i_irq,
  input  logic    i_clear_all,
  input  logic    i_csr_wr,
  input  csr_op_e i_csr_op,
  input  logic    i_wbit,
  output logic    o_mip
);

  logic w_irq_s;
  logic w_edge;
  logic w_pend_csr;
  logic r_prev;
  logic r_pend;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign w_irq_s = i_irq;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] r_sync;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_sync <= '0;
      else       r_sync <= SYNC_STAGES'({r_sync, i_irq});
    end
    assign w_irq_s = r_sync[SYNC_STAGES-1];
  end

  assign w_edge     = w_irq_s & ~r_prev;
  assign w_pend_csr = i_csr_wr ? csr_apply(i_csr_op, r_pend, i_wbit) : r_pend;

  // OR-ing the edge after the CSR update means a same-cycle clear never drops an edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prev <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_prev <= w_irq_s;
      r_pend <= i_clear_all ? 1'b0 : (w_pend_csr | w_edge);
    end
  end

  assign o_mip = EDGE ? r_pend : w_irq_s;

endmodule

// File: rtl/tinyqv_irq_ctrl.sv
// NUM_IRQ-line interrupt controller with nibble-serial mie/mip CSRs and take-time priority latch.
// Optional TINYQV_IRQ_VECTORED_EN adds a registered vec_offset; no backpressure, CSR nibble per clock.
module tinyqv_irq_ctrl
  import tinyqv_irq_pkg::*;
#(
  parameter int          NUM_IRQ     = 4,
  parameter int          IRQ_BASE    = 16,
  parameter logic [15:0] EDGE_MASK   = 16'h0003,
  parameter int          SYNC_STAGES = 0
) (
  input logic              clk,
  input logic              rstn,
  tinyqv_irq_ctrl_if.slave bus
);

  csr_op_e            w_op;
  logic               w_mie_wr;
  logic               w_mip_wr;
  logic [NUM_IRQ-1:0] r_mie;
  logic [NUM_IRQ-1:0] w_mie_nxt;
  logic [NUM_IRQ-1:0] w_mip;
  logic [NUM_IRQ-1:0] w_act;
  logic [31:0]        w_mie32;
  logic [31:0]        w_mip32;
  logic [31:0]        w_rd32;
  logic               w_hit;
  logic [3:0]         w_lowest;
  logic [3:0]         r_irq_id;

  assign w_op     = csr_op_e'(bus.csr_op);
  assign w_mie_wr = (bus.csr_addr == CSR_MIE) && (w_op != CSR_OP_NONE);
  assign w_mip_wr = (bus.csr_addr == CSR_MIP) && (w_op != CSR_OP_NONE);

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    localparam logic [2:0] NIB = nib_of(IRQ_BASE + i);
    logic w_nib;
    assign w_nib = (bus.counter == NIB);
    assign w_mie_nxt[i] = (w_mie_wr && w_nib) ? csr_apply(w_op, r_mie[i], bus.csr_wdata[i % 4])
                                              : r_mie[i];

    tinyqv_irq_line #(
      .EDGE        (EDGE_MASK[i]),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_line (
      .clk         (clk),
      .rstn        (rstn),
      .i_irq       (bus.irq_in[i]),
      .i_clear_all (bus.clear_all),
      .i_csr_wr    (w_mip_wr && w_nib),
      .i_csr_op    (w_op),
      .i_wbit      (bus.csr_wdata[i % 4]),
      .o_mip       (w_mip[i])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              r_mie <= '0;
    else if (bus.clear_all) r_mie <= '0;
    else                    r_mie <= w_mie_nxt;
  end

  assign w_mie32       = 32'(r_mie) << IRQ_BASE;
  assign w_mip32       = 32'(w_mip) << IRQ_BASE;
  assign w_rd32        = (bus.csr_addr == CSR_MIE) ? w_mie32 :
                         (bus.csr_addr == CSR_MIP) ? w_mip32 : '0;
  assign bus.csr_rdata = w_rd32[{bus.counter, 2'b00} +: 4];

  assign w_act                 = w_mip & r_mie;
  assign bus.interrupt_pending = bus.global_ie && (|w_act);

  // Scan downwards so the lowest enabled pending line wins.
  always_comb begin
    w_hit    = 1'b0;
    w_lowest = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_act[i]) begin
        w_hit    = 1'b1;
        w_lowest = 4'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                               r_irq_id <= '0;
    else if (bus.take_irq && (bus.counter == 3'd0) && w_hit) r_irq_id <= w_lowest;
  end
  assign bus.irq_id = r_irq_id;

`ifdef TINYQV_IRQ_VECTORED_EN
  logic [6:0] r_vec_offset;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                               r_vec_offset <= '0;
    else if (bus.take_irq && (bus.counter == 3'd0) && w_hit) r_vec_offset <= 7'((IRQ_BASE + int'(w_lowest)) * 4);
  end
  assign bus.vec_offset = r_vec_offset;
`endif

endmodule

// File: tb/tb_tinyqv_irq_ctrl.sv
// Bench: two controller configurations driven by shared CSR/control stimulus, checked against a
// CSR-space (32-bit word) behavioural model every cycle, plus literal checks of the headline scenarios.
module tb_tinyqv_irq_ctrl;
  import tinyqv_irq_pkg::*;

  localparam int          NA   = 4;
  localparam int          NB   = 16;
  localparam int          BASE = 16;
  localparam logic [15:0] EA   = 16'h0003;
  localparam logic [15:0] EB   = 16'h8003;
  localparam int          SA   = 0;
  localparam int          SB   = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  tinyqv_irq_ctrl_if #(.NUM_IRQ(NA)) ifa ();
  tinyqv_irq_ctrl_if #(.NUM_IRQ(NB)) ifb ();

  tinyqv_irq_ctrl #(.NUM_IRQ(NA), .IRQ_BASE(BASE), .EDGE_MASK(EA), .SYNC_STAGES(SA)) dut_a (
    .clk(clk), .rstn(rstn), .bus(ifa));
  tinyqv_irq_ctrl #(.NUM_IRQ(NB), .IRQ_BASE(BASE), .EDGE_MASK(EB), .SYNC_STAGES(SB)) dut_b (
    .clk(clk), .rstn(rstn), .bus(ifb));

  int total = 0;
  int bad   = 0;

  logic [2:0]  cnt;
  logic [11:0] v_addr;
  logic [1:0]  v_op;
  logic [3:0]  v_wd;
  logic        v_take, v_gie, v_ca;
  logic [15:0] irqv [2];

  logic [31:0] m_mie  [2];
  logic [31:0] m_pend [2];
  logic [15:0] m_hist [2][4];
  logic [3:0]  m_id   [2];

  logic [3:0]  obs_rd [2];
  logic [3:0]  obs_id [2];
  logic        obs_ip [2];

  function automatic int nsync(input int d);
    return (d == 0) ? SA : SB;
  endfunction

  function automatic logic [15:0] lmask(input int d);
    return (d == 0) ? 16'h000F : 16'hFFFF;
  endfunction

  function automatic logic [15:0] emask(input int d);
    return ((d == 0) ? EA : EB) & lmask(d);
  endfunction

  function automatic logic [15:0] irq_s(input int d);
    return (nsync(d) == 0) ? (irqv[d] & lmask(d)) : m_hist[d][nsync(d) - 1];
  endfunction

  function automatic logic [31:0] mip_word(input int d);
    return m_pend[d] | ({16'h0, irq_s(d) & ~emask(d) & lmask(d)} << BASE);
  endfunction

  function automatic logic [31:0] apply(input logic [31:0] cur, input int sh);
    logic [31:0] nm;
    logic [31:0] wd;
    nm = 32'hF << sh;
    wd = {28'h0, v_wd} << sh;
    case (v_op)
      2'b01:   return (cur & ~nm) | wd;
      2'b10:   return cur | wd;
      2'b11:   return cur & ~wd;
      default: return cur;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mie[d]  = '0;
      m_pend[d] = '0;
      m_id[d]   = '0;
      for (int k = 0; k < 4; k++) m_hist[d][k] = '0;
    end
  endtask

  task automatic drive();
    ifa.counter = cnt;  ifa.csr_addr = v_addr; ifa.csr_op = v_op; ifa.csr_wdata = v_wd;
    ifa.take_irq = v_take; ifa.global_ie = v_gie; ifa.clear_all = v_ca; ifa.irq_in = irqv[0][NA-1:0];
    ifb.counter = cnt;  ifb.csr_addr = v_addr; ifb.csr_op = v_op; ifb.csr_wdata = v_wd;
    ifb.take_irq = v_take; ifb.global_ie = v_gie; ifb.clear_all = v_ca; ifb.irq_in = irqv[1];
  endtask

  // One clock: drive at negedge, compare at negedge+1, advance the model at the posedge.
  task automatic cyc();
    logic [31:0] n_mie [2];
    logic [31:0] n_pend[2];
    logic [3:0]  n_id  [2];
    logic [31:0] mp, act, rd, e32, l32, edg;
    int sh;
    @(negedge clk);
    drive();
    #1;
    sh = 4 * int'(cnt);
    obs_rd[0] = ifa.csr_rdata; obs_ip[0] = ifa.interrupt_pending; obs_id[0] = ifa.irq_id;
    obs_rd[1] = ifb.csr_rdata; obs_ip[1] = ifb.interrupt_pending; obs_id[1] = ifb.irq_id;
    for (int d = 0; d < 2; d++) begin
      mp  = mip_word(d);
      act = mp & m_mie[d];
      l32 = {16'h0, lmask(d)} << BASE;
      e32 = {16'h0, emask(d)} << BASE;
      rd  = (v_addr == CSR_MIE) ? m_mie[d] : (v_addr == CSR_MIP) ? mp : 32'h0;
      chk($sformatf("rdata[%0d]", d), 32'(obs_rd[d]), (rd >> sh) & 32'hF);
      chk($sformatf("pending[%0d]", d), 32'(obs_ip[d]), 32'(v_gie && (act != 0)));
      chk($sformatf("irq_id[%0d]", d), 32'(obs_id[d]), 32'(m_id[d]));
`ifdef TINYQV_IRQ_VECTORED_EN
      chk($sformatf("vec_offset[%0d]", d), 32'((d == 0) ? ifa.vec_offset : ifb.vec_offset),
          32'(4 * (BASE + int'(m_id[d]))));
`endif
      edg = {16'h0, irq_s(d) & ~m_hist[d][nsync(d)] & emask(d)} << BASE;
      n_mie[d]  = v_ca ? 32'h0 : ((v_addr == CSR_MIE) ? (apply(m_mie[d], sh) & l32) : m_mie[d]);
      n_pend[d] = v_ca ? 32'h0 : ((((v_addr == CSR_MIP) ? apply(m_pend[d], sh) : m_pend[d]) | edg) & e32);
      n_id[d]   = m_id[d];
      if (v_take && cnt == 3'd0 && act != 0)
        for (int i = 15; i >= 0; i--) if (act[BASE + i]) n_id[d] = 4'(i);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      m_mie[d]  = n_mie[d];
      m_pend[d] = n_pend[d];
      m_id[d]   = n_id[d];
      for (int k = 3; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
      m_hist[d][0] = irqv[d] & lmask(d);
    end
    cnt = cnt + 3'd1;
  endtask

  task automatic align(input logic [2:0] k);
    for (int g = 0; g < 8 && cnt != k; g++) cyc();
  endtask

  task automatic op_at(input logic [2:0] k, input logic [11:0] a, input logic [1:0] op, input logic [3:0] wd);
    v_op = 2'b00;
    align(k);
    v_addr = a; v_op = op; v_wd = wd;
    cyc();
    v_op = 2'b00; v_wd = 4'h0;
  endtask

  initial begin
    cnt = 3'd0; v_addr = 12'h0; v_op = 2'b00; v_wd = 4'h0;
    v_take = 1'b0; v_gie = 1'b0; v_ca = 1'b0; irqv[0] = '0; irqv[1] = '0;
    drive();
    model_reset();
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;

    v_addr = CSR_MIP;
    cyc();
    chk("reset_rdata", 32'(obs_rd[0]), 0);
    chk("reset_pending", 32'(obs_ip[0]), 0);
    chk("reset_irq_id", 32'(obs_id[0]), 0);

    op_at(3'd4, CSR_MIE, 2'b01, 4'h1);
    v_gie = 1'b1; irqv[0] = 16'h0001;
    cyc(); chk("edge_not_yet", 32'(obs_ip[0]), 0);
    cyc(); chk("edge_pending", 32'(obs_ip[0]), 1);
    v_gie = 1'b0;
    cyc(); chk("gie_off", 32'(obs_ip[0]), 0);
    v_gie = 1'b1;
    op_at(3'd4, CSR_MIP, 2'b11, 4'h1);
    chk("mip_bit16", 32'(obs_rd[0]), 1);

    irqv[0] = 16'h0005;
    op_at(3'd4, CSR_MIP, 2'b10, 4'h4);
    chk("level_high", 32'(obs_rd[0]), 4);
    irqv[0] = 16'h0001;
    op_at(3'd4, CSR_MIP, 2'b00, 4'h0);
    chk("level_low_set_ignored", 32'(obs_rd[0]), 0);

    op_at(3'd4, CSR_MIE, 2'b01, 4'hF);
    irqv[0] = 16'h000B;
    cyc();
    align(3'd0); v_take = 1'b1; cyc(); v_take = 1'b0; cyc();
    chk("prio_id1", 32'(obs_id[0]), 1);
`ifdef TINYQV_IRQ_VECTORED_EN
    chk("prio_vec68", 32'(ifa.vec_offset), 68);
`endif
    op_at(3'd4, CSR_MIP, 2'b11, 4'h2);
    align(3'd0); v_take = 1'b1; cyc(); v_take = 1'b0; cyc();
    chk("prio_id3", 32'(obs_id[0]), 3);

    irqv[0] = 16'h000A;
    cyc();
    align(3'd4);
    irqv[0] = 16'h000B; v_addr = CSR_MIP; v_op = 2'b11; v_wd = 4'h9;
    cyc();
    v_op = 2'b00; v_wd = 4'h0;
    op_at(3'd4, CSR_MIP, 2'b00, 4'h0);
    chk("race_edge_wins", 32'(obs_rd[0]), 9);

    op_at(3'd7, CSR_MIE, 2'b01, 4'h8);
    align(3'd3);
    irqv[1] = 16'h8000;
    cyc(); chk("sync_t0", 32'(obs_ip[1]), 0);
    cyc(); chk("sync_t1", 32'(obs_ip[1]), 0);
    cyc(); chk("sync_t2", 32'(obs_ip[1]), 0);
    cyc(); chk("sync_t3", 32'(obs_ip[1]), 1);
    v_addr = CSR_MIP;
    cyc(); chk("mip_bit31", 32'(obs_rd[1]), 8);

    irqv[0] = '0;
    op_at(3'd4, CSR_MIP, 2'b01, 4'h3);
    cyc(); chk("pre_clear_all", 32'(obs_ip[0]), 1);
    v_ca = 1'b1; cyc(); v_ca = 1'b0;
    cyc(); chk("clear_all_a", 32'(obs_ip[0]), 0);
    chk("clear_all_b", 32'(obs_ip[1]), 0);
    op_at(3'd4, CSR_MIE, 2'b00, 4'h0);
    chk("clear_all_mie", 32'(obs_rd[0]), 0);

    op_at(3'd4, CSR_MIE, 2'b01, 4'hF);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    chk("async_rst_mie", 32'(ifa.csr_rdata), 0);
    chk("async_rst_pending", 32'(ifa.interrupt_pending), 0);
    @(posedge clk);
    #2 rstn = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0:       v_addr = CSR_MIE;
        1, 2:    v_addr = CSR_MIP;
        default: v_addr = 12'($urandom);
      endcase
      v_op   = 2'($urandom);
      v_wd   = 4'($urandom);
      v_take = ($urandom_range(0, 3) == 0);
      v_gie  = ($urandom_range(0, 7) != 0);
      v_ca   = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) == 0) irqv[0] = irqv[0] ^ (16'(1) << $urandom_range(0, NA - 1));
      if ($urandom_range(0, 1) == 0) irqv[1] = irqv[1] ^ (16'(1) << $urandom_range(0, NB - 1));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
